// File: rtl/seg_pkg.sv
// Shared codes, slot indices and active-low segment patterns for the
// seven-segment display blocks.
package seg_pkg;

    typedef logic [4:0] code_t;
    typedef logic [6:0] seg_t;

    localparam code_t CODE_BLANK = 5'b11111;
    localparam code_t CODE_MINUS = 5'b10001;

    localparam logic [2:0] SLOT_SIGN  = 3'd0;
    localparam logic [2:0] SLOT_H_MIN = 3'd1;
    localparam logic [2:0] SLOT_L_MIN = 3'd2;
    localparam logic [2:0] SLOT_H_SEC = 3'd3;
    localparam logic [2:0] SLOT_L_SEC = 3'd4;
    localparam int         NUM_SLOTS  = 5;

    // Segment order is {g,f,e,d,c,b,a}, a lit segment is 0.
    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_MINUS = 7'b0111111;
    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_E     = 7'b0000110;

    localparam logic [4:0] DIG_NONE = 5'b11111;

    function automatic logic [4:0] slot_enable_n(input logic [2:0] slot);
        logic [4:0] one;
        one = 5'b00001;
        return ~(one << slot);
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational 5-bit display code to active-low seven-segment pattern.
// Codes outside 0..9, minus and blank render as 'E'.
module seg_decoder
    import seg_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_E;
        case (code)
            5'd0:       seg = SEG_0;
            5'd1:       seg = SEG_1;
            5'd2:       seg = SEG_2;
            5'd3:       seg = SEG_3;
            5'd4:       seg = SEG_4;
            5'd5:       seg = SEG_5;
            5'd6:       seg = SEG_6;
            5'd7:       seg = SEG_7;
            5'd8:       seg = SEG_8;
            5'd9:       seg = SEG_9;
            CODE_MINUS: seg = SEG_MINUS;
            CODE_BLANK: seg = SEG_BLANK;
            default:    seg = SEG_E;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Five-digit multiplexed display scanner for the countdown timer: frame-
// coherent input snapshot, per-slot dead time, and a blinking separator in overtime.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 50
) (
    input  logic       input_clk,
    input  logic       reset,
    input  logic [4:0] in_sign,
    input  logic [4:0] in_H_min,
    input  logic [4:0] in_L_min,
    input  logic [4:0] in_H_sec,
    input  logic [4:0] in_L_sec,
    output logic [7:0] seg_n,
    output logic [4:0] dig_n
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [SW-1:0] scan_cnt;
    logic [2:0]    pos;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    logic [4:0] snap_sign;
    logic [4:0] snap_h_min;
    logic [4:0] snap_l_min;
    logic [4:0] snap_h_sec;
    logic [4:0] snap_l_sec;

    logic       slot_end;
    logic       frame_end;
    logic [4:0] cur_code;
    logic [6:0] cur_seg;
    logic       dp_n;

    assign slot_end  = (scan_cnt == SCAN_LAST);
    assign frame_end = slot_end && (pos == SLOT_L_SEC);

    always_ff @(posedge input_clk) begin
        if (reset) begin
            scan_cnt <= '0;
            pos      <= SLOT_SIGN;
        end else if (slot_end) begin
            scan_cnt <= '0;
            pos      <= (pos == SLOT_L_SEC) ? SLOT_SIGN : pos + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    // Blink timing runs off frame completions whatever the sign shows.
    always_ff @(posedge input_clk) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_end) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    // Inputs are sampled only on the last cycle of a frame so a frame never
    // mixes old and new timer values.
    always_ff @(posedge input_clk) begin
        if (reset) begin
            snap_sign  <= CODE_BLANK;
            snap_h_min <= CODE_BLANK;
            snap_l_min <= CODE_BLANK;
            snap_h_sec <= CODE_BLANK;
            snap_l_sec <= CODE_BLANK;
        end else if (frame_end) begin
            snap_sign  <= in_sign;
            snap_h_min <= in_H_min;
            snap_l_min <= in_L_min;
            snap_h_sec <= in_H_sec;
            snap_l_sec <= in_L_sec;
        end
    end

    always_comb begin
        cur_code = CODE_BLANK;
        case (pos)
            SLOT_SIGN:  cur_code = snap_sign;
            SLOT_H_MIN: cur_code = snap_h_min;
            SLOT_L_MIN: cur_code = snap_l_min;
            SLOT_H_SEC: cur_code = snap_h_sec;
            SLOT_L_SEC: cur_code = snap_l_sec;
            default:    cur_code = CODE_BLANK;
        endcase
    end

    seg_decoder u_decoder (
        .code (cur_code),
        .seg  (cur_seg)
    );

    // Separator follows the L_min digit; in overtime it blinks with blink_phase.
    always_comb begin
        dp_n = 1'b1;
        if (pos == SLOT_L_MIN) begin
            if (snap_sign != CODE_MINUS)
                dp_n = 1'b0;
            else
                dp_n = ~blink_phase;
        end
    end

    // First cycle of every slot is dark to avoid ghosting while digits switch.
    always_ff @(posedge input_clk) begin
        if (reset) begin
            seg_n <= 8'hFF;
            dig_n <= DIG_NONE;
        end else if (scan_cnt == '0) begin
            seg_n <= 8'hFF;
            dig_n <= DIG_NONE;
        end else begin
            seg_n <= {dp_n, cur_seg};
            dig_n <= slot_enable_n(pos);
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=4, BLINK_FRAMES=2; expected
// {dig_n, seg_n} per cycle are queued per frame and compared as the DUT scans.
module tb_seg_scan_driver;

    localparam int SCAN_DIV     = 4;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME_CYC    = SCAN_DIV * 5;

    logic       input_clk = 1'b0;
    logic       reset;
    logic [4:0] in_sign;
    logic [4:0] in_H_min;
    logic [4:0] in_L_min;
    logic [4:0] in_H_sec;
    logic [4:0] in_L_sec;
    logic [7:0] seg_n;
    logic [4:0] dig_n;

    logic [12:0] exp_q[$];
    logic [4:0]  snap_m[5];
    int          fr;
    int          checks = 0;
    int          errors = 0;

    seg_scan_driver #(
        .SCAN_DIV     (SCAN_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .input_clk (input_clk),
        .reset     (reset),
        .in_sign   (in_sign),
        .in_H_min  (in_H_min),
        .in_L_min  (in_L_min),
        .in_H_sec  (in_H_sec),
        .in_L_sec  (in_L_sec),
        .seg_n     (seg_n),
        .dig_n     (dig_n)
    );

    always #5 input_clk = ~input_clk;

    function automatic logic [6:0] ref_seg(input logic [4:0] c);
        case (c)
            5'd0:     return 7'b1000000;
            5'd1:     return 7'b1111001;
            5'd2:     return 7'b0100100;
            5'd3:     return 7'b0110000;
            5'd4:     return 7'b0011001;
            5'd5:     return 7'b0010010;
            5'd6:     return 7'b0000010;
            5'd7:     return 7'b1111000;
            5'd8:     return 7'b0000000;
            5'd9:     return 7'b0010000;
            5'b10001: return 7'b0111111;
            5'b11111: return 7'b1111111;
            default:  return 7'b0000110;
        endcase
    endfunction

    task automatic set_in(input logic [4:0] s, input logic [4:0] hm, input logic [4:0] lm,
                          input logic [4:0] hs, input logic [4:0] ls);
        in_sign  = s;
        in_H_min = hm;
        in_L_min = lm;
        in_H_sec = hs;
        in_L_sec = ls;
    endtask

    // Queue the first n cycles of the frame shown from the current model snapshot.
    task automatic begin_frame(input int n);
        logic [4:0] dig;
        logic       dp;
        int         slot;
        for (int k = 0; k < n; k++) begin
            slot = k / SCAN_DIV;
            if (k % SCAN_DIV == 0) begin
                exp_q.push_back(13'h1FFF);
            end else begin
                dig = 5'b11111;
                dig[slot] = 1'b0;
                dp = 1'b1;
                if (slot == 2 && (snap_m[0] != 5'b10001 || ((fr / BLINK_FRAMES) % 2) == 1))
                    dp = 1'b0;
                exp_q.push_back({dig, dp, ref_seg(snap_m[slot])});
            end
        end
    endtask

    task automatic end_frame();
        snap_m[0] = in_sign;
        snap_m[1] = in_H_min;
        snap_m[2] = in_L_min;
        snap_m[3] = in_H_sec;
        snap_m[4] = in_L_sec;
        fr++;
    endtask

    task automatic step(input int n, input string tag);
        logic [12:0] exp_v;
        for (int i = 0; i < n; i++) begin
            @(posedge input_clk);
            @(negedge input_clk);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL %s queue_empty got %h exp none", tag, {dig_n, seg_n});
            end else begin
                exp_v = exp_q.pop_front();
                assert ({dig_n, seg_n} === exp_v) else begin
                    errors++;
                    $error("FAIL %s cyc%0d got dig=%b seg=%b exp dig=%b seg=%b",
                           tag, i, dig_n, seg_n, exp_v[12:8], exp_v[7:0]);
                end
            end
        end
    endtask

    task automatic run_frame(input string tag);
        begin_frame(FRAME_CYC);
        step(FRAME_CYC, tag);
        end_frame();
    endtask

    initial begin
        reset = 1'b1;
        set_in(5'b11111, 5'd2, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 3; i++) exp_q.push_back(13'h1FFF);
        step(3, "reset_hold");
        reset = 1'b0;
        for (int i = 0; i < 5; i++) snap_m[i] = 5'b11111;
        fr = 0;

        run_frame("blank_frame0");

        // Frame 1 shows " 2000"; arm L_sec=9 for the next snapshot.
        begin_frame(FRAME_CYC);
        step(7, "digits_2000");
        set_in(5'b11111, 5'd2, 5'd0, 5'd0, 5'd9);
        step(FRAME_CYC - 7, "digits_2000");
        end_frame();

        // Mid-frame change of L_sec must not show until the next frame.
        begin_frame(FRAME_CYC);
        step(10, "lsec9_pre");
        set_in(5'b11111, 5'd2, 5'd0, 5'd0, 5'd8);
        step(FRAME_CYC - 10, "lsec9_hold");
        end_frame();

        begin_frame(FRAME_CYC);
        step(5, "lsec8");
        set_in(5'b10001, 5'd1, 5'd2, 5'b01100, 5'd8);
        step(FRAME_CYC - 5, "lsec8");
        end_frame();

        // Overtime frames 4..7: dp high, high, low, low.
        begin_frame(FRAME_CYC);
        step(3, "ot_f4");
        set_in(5'b10001, 5'd4, 5'd7, 5'd6, 5'b11111);
        step(FRAME_CYC - 3, "ot_f4");
        end_frame();

        begin_frame(FRAME_CYC);
        step(12, "ot_f5");
        set_in(5'b10001, 5'd3, 5'd9, 5'b01010, 5'b11110);
        step(FRAME_CYC - 12, "ot_f5");
        end_frame();

        begin_frame(FRAME_CYC);
        step(2, "ot_f6");
        set_in(5'd1, 5'd5, 5'b10000, 5'b10010, 5'd1);
        step(FRAME_CYC - 2, "ot_f6");
        end_frame();

        run_frame("ot_f7");
        run_frame("sign1_f8");

        // Reset landing exactly on the snapshot cycle must discard the inputs.
        begin_frame(FRAME_CYC - 1);
        step(FRAME_CYC - 1, "pre_snap_reset");
        set_in(5'd8, 5'd8, 5'd8, 5'd8, 5'd8);
        reset = 1'b1;
        exp_q.push_back(13'h1FFF);
        step(1, "snap_reset");
        reset = 1'b0;
        for (int i = 0; i < 5; i++) snap_m[i] = 5'b11111;
        fr = 0;

        run_frame("post_reset_blank");
        run_frame("post_reset_8888");

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL queue_drain got %0d exp 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, clocks per digit slot (legal >= 2).
REQ-002 SHALL have parameter BLINK_FRAMES, default 50, full frames per blink half-period (legal >= 1).
REQ-003 SHALL have port input_clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_sign  input  5  sign digit code from the countdown timer.
REQ-006 SHALL have ports in_H_min, in_L_min, in_H_sec, in_L_sec  input  5 each  timer digit codes.
REQ-007 SHALL have port seg_n  output  8  registered segments, active-low; [0]=a .. [6]=g, [7]=dp.
REQ-008 SHALL have port dig_n  output  5  registered digit enables, active-low; [0]=sign, [1]=H_min, [2]=L_min, [3]=H_sec, [4]=L_sec.

Function
REQ-009 SHALL keep scan_cnt counting 0..SCAN_DIV-1, then wrapping to 0 and advancing slot pos 0..4, wrapping 4->0.
REQ-010 SHALL capture all five inputs into a snapshot register in the cycle pos==4 and scan_cnt==SCAN_DIV-1; inputs are ignored at all other times (no mid-frame tearing).
REQ-011 SHALL drive, one cycle after a cycle with scan_cnt==0, dig_n=5'b11111 (dead time, anti-ghosting).
REQ-012 SHALL drive, one cycle after a cycle with scan_cnt>=1, dig_n with only bit pos low, and seg_n[6:0]=decode(snapshot[pos]).
REQ-013 SHALL decode codes 0..9 to standard digits (0 -> 7'b1000000, 1 -> 7'b1111001, 2 -> 7'b0100100, 8 -> 7'b0000000).
REQ-014 SHALL decode 5'b10001 to minus (7'b0111111) and 5'b11111 to blank (7'b1111111).
REQ-015 SHALL decode every other code (10..16, 18..30) to 'E' (7'b0000110).
REQ-016 SHALL hold seg_n[7] (dp) high except in slot pos==2 (minute/second separator).
REQ-017 SHALL, in slot 2, drive dp low steadily when snapshot sign != 5'b10001.
REQ-018 SHALL, in slot 2 with snapshot sign == 5'b10001 (overtime), drive dp low only while blink_phase==1.
REQ-019 SHALL count completed frames (pos 4->0 wraps) in blink_cnt 0..BLINK_FRAMES-1, toggling blink_phase at each wrap.
REQ-020 SHALL keep blink_cnt and blink_phase running regardless of sign; sign affects only dp gating.
REQ-021 SHALL apply an input change at the next snapshot point only, with no other side effects.

Reset
REQ-022 SHALL make reset take priority over all other activity, including mid-frame and in the snapshot cycle.
REQ-023 SHALL, on reset, clear scan_cnt, pos, blink_cnt and blink_phase to 0.
REQ-024 SHALL, on reset, set all snapshot codes to 5'b11111 (blank).
REQ-025 SHALL, on reset, set seg_n=8'hFF and dig_n=5'b11111 in the cycle after reset is sampled.
REQ-026 SHALL show the first frame after reset as blank, with the first live snapshot at the end of that frame.

Structure
REQ-027 SHALL place CODE_BLANK=5'b11111, CODE_MINUS=5'b10001, the digit-slot indices and the segment pattern constants in shared package seg_pkg.
REQ-028 SHALL implement decode in one combinational sub-module, seg_decoder (5-bit code -> 7 active-low segments), reused by future display blocks.
REQ-029 SHALL size counter widths via $clog2 of the parameters; no other sub-modules.

Verification (SCAN_DIV=4, BLINK_FRAMES=2)
REQ-030 SHALL test: reset held 3 cycles, then released -> seg_n=8'hFF, dig_n=5'b11111 during reset; first 20 cycles all slots show blank; dead cycle every 4th cycle.
REQ-031 SHALL test: inputs sign=5'b11111, 2,0,0,0 before first snapshot -> second frame shows slots blank, 7'b0100100, 7'b1000000, 7'b1000000, 7'b1000000; dp low steadily in slot 2.
REQ-032 SHALL test: in_L_sec changed 9 -> 8 mid-frame -> slot 4 shows 9 until the frame ends, then shows 8.
REQ-033 SHALL test: sign=5'b10001 -> slot 0 shows 7'b0111111; slot-2 dp alternates low/high every 2 frames.
REQ-034 SHALL test: code 5'b01100 on H_sec -> 7'b0000110 ('E'); code 5'b11111 -> 7'b1111111.
REQ-035 SHALL test: reset asserted in the snapshot cycle (pos=4, scan_cnt=3) -> snapshot is blank, not the inputs; pos=0 and scan_cnt=0 after release.
